// File: rtl/sssp_update_packer.sv
// Compacts per-pipeline 64-bit SSSP vertex updates into dense 8-slot lines
// and queues them in a small line FIFO with end-of-stream flush and overflow tracking.
module sssp_update_packer #(
    parameter int unsigned N_PIPE     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PIPE*64-1:0]   upd_in,
    input  logic [N_PIPE-1:0]      upd_valid,
    input  logic [1:0]             control_in,
    input  logic                   last_input_in,
    output logic [511:0]           line_out,
    output logic [7:0]             line_mask,
    output logic                   line_valid,
    input  logic                   line_ready,
    output logic                   in_ready,
    output logic                   done_out,
    output logic [31:0]            update_count,
    output logic                   overflow
);

    localparam int unsigned SLOTS  = 8;
    localparam int unsigned UPD_W  = 64;
    localparam int unsigned LINE_W = SLOTS * UPD_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] CTRL_IMPORT = 2'h1;
    localparam logic [1:0] CTRL_STREAM = 2'h2;

    logic [SLOTS-1:0][UPD_W-1:0] acc_q, acc_n;
    logic [2:0]                  fill_q, fill_n;
    logic                        flush_pend_q, flush_pend_n;
    logic                        flush_issued_q, flush_issued_n;
    logic [31:0]                 upd_count_n;
    logic                        overflow_n, done_n, in_ready_n, line_valid_n;

    logic [LINE_W-1:0]           mem_line [FIFO_DEPTH];
    logic [SLOTS-1:0]            mem_mask [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q, head_idx;
    logic [CNT_W-1:0]            count_q, count_n;
    logic [LINE_W-1:0]           line_out_n;
    logic [SLOTS-1:0]            line_mask_n;

    logic                        push, lost, flush_now, pop, full, wr_en, drop;
    logic [LINE_W-1:0]           push_line;
    logic [SLOTS-1:0]            push_mask;
    logic [2*SLOTS-1:0][UPD_W-1:0] ext;
    logic [SLOTS-1:0][UPD_W-1:0] base_acc;
    logic [2:0]                  base_fill;
    logic [3:0]                  cnt, k;

    function automatic logic [7:0] low_mask(input logic [2:0] n);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

    // Compaction, line completion, flush and clear bookkeeping
    always_comb begin
        acc_n          = acc_q;
        fill_n         = fill_q;
        flush_pend_n   = flush_pend_q;
        flush_issued_n = flush_issued_q;
        upd_count_n    = update_count;
        overflow_n     = overflow;
        done_n         = 1'b0;
        push           = 1'b0;
        push_line      = '0;
        push_mask      = '0;
        lost           = 1'b0;
        flush_now      = 1'b0;
        ext            = '0;
        cnt            = '0;
        k              = '0;
        base_acc       = flush_pend_q ? '0 : acc_q;
        base_fill      = flush_pend_q ? 3'd0 : fill_q;

        for (int i = 0; i < N_PIPE; i++) begin
            k = k + 4'(upd_valid[i]);
        end

        if (control_in == CTRL_IMPORT) begin
            acc_n          = '0;
            fill_n         = '0;
            flush_pend_n   = 1'b0;
            flush_issued_n = 1'b0;
            upd_count_n    = '0;
            overflow_n     = 1'b0;
        end else begin
            if (flush_pend_q) begin
                push         = 1'b1;
                push_line    = acc_q;
                push_mask    = low_mask(fill_q);
                flush_pend_n = 1'b0;
            end
            acc_n  = base_acc;
            fill_n = base_fill;

            if (control_in == CTRL_STREAM) begin
                upd_count_n = update_count + 32'(k);
                ext[SLOTS-1:0] = base_acc;
                cnt = 4'(base_fill);
                for (int i = 0; i < N_PIPE; i++) begin
                    if (upd_valid[i]) begin
                        ext[cnt] = upd_in[i*UPD_W +: UPD_W];
                        cnt      = cnt + 4'd1;
                    end
                end
                if (cnt >= 4'd8) begin
                    // A second line in one cycle only happens behind a pending flush
                    if (push) begin
                        lost = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_line = ext[SLOTS-1:0];
                        push_mask = 8'hFF;
                    end
                    acc_n  = ext[2*SLOTS-1:SLOTS];
                    fill_n = 3'(cnt - 4'd8);
                end else begin
                    acc_n  = ext[SLOTS-1:0];
                    fill_n = cnt[2:0];
                end
                if (last_input_in) begin
                    flush_now      = 1'b1;
                    flush_issued_n = 1'b1;
                    if (fill_n != 3'd0) begin
                        if (push) begin
                            flush_pend_n = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_line = acc_n;
                            push_mask = low_mask(fill_n);
                            acc_n     = '0;
                            fill_n    = '0;
                        end
                    end
                end
            end

            done_n = flush_issued_q && !flush_pend_q && (count_q == '0) && !push;
            if (done_n && !flush_now) begin
                flush_issued_n = 1'b0;
            end
        end

        pop          = line_valid && line_ready;
        full         = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en        = push && (!full || pop);
        drop         = push && !wr_en;
        overflow_n   = overflow_n | drop | lost;
        count_n      = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        head_idx     = pop ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        line_valid_n = (count_n != '0);
        in_ready_n   = ((CNT_W'(FIFO_DEPTH) - count_n) >= CNT_W'(2));

        // Output register preloads the next head, bypassing a write into an empty slot
        line_out_n  = line_out;
        line_mask_n = line_mask;
        if (count_n != '0) begin
            if (wr_en && (wr_ptr_q == head_idx)) begin
                line_out_n  = push_line;
                line_mask_n = push_mask;
            end else begin
                line_out_n  = mem_line[head_idx];
                line_mask_n = mem_mask[head_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q          <= '0;
            fill_q         <= '0;
            flush_pend_q   <= 1'b0;
            flush_issued_q <= 1'b0;
            update_count   <= '0;
            overflow       <= 1'b0;
            done_out       <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            line_out       <= '0;
            line_mask      <= '0;
            line_valid     <= 1'b0;
            in_ready       <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_line[i] <= '0;
                mem_mask[i] <= '0;
            end
        end else begin
            acc_q          <= acc_n;
            fill_q         <= fill_n;
            flush_pend_q   <= flush_pend_n;
            flush_issued_q <= flush_issued_n;
            update_count   <= upd_count_n;
            overflow       <= overflow_n;
            done_out       <= done_n;
            count_q        <= count_n;
            line_out       <= line_out_n;
            line_mask      <= line_mask_n;
            line_valid     <= line_valid_n;
            in_ready       <= in_ready_n;
            if (wr_en) begin
                mem_line[wr_ptr_q] <= push_line;
                mem_mask[wr_ptr_q] <= push_mask;
                wr_ptr_q           <= PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop) begin
                rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_sssp_update_packer.sv
// Scoreboard bench for sssp_update_packer: directed update streams, a queue of
// expected lines, and a monitor that checks every transferred line.
module tb_sssp_update_packer;

    localparam int unsigned N_PIPE     = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] WK         = 32'hA5A5_0000;

    logic                 clk;
    logic                 rst;
    logic [N_PIPE*64-1:0] upd_in;
    logic [N_PIPE-1:0]    upd_valid;
    logic [1:0]           control_in;
    logic                 last_input_in;
    logic [511:0]         line_out;
    logic [7:0]           line_mask;
    logic                 line_valid;
    logic                 line_ready;
    logic                 in_ready;
    logic                 done_out;
    logic [31:0]          update_count;
    logic                 overflow;

    typedef struct packed {
        logic [511:0] line;
        logic [7:0]   mask;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int last_pop = 0;
    int prev_pop = 0;

    sssp_update_packer #(.N_PIPE(N_PIPE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .upd_in       (upd_in),
        .upd_valid    (upd_valid),
        .control_in   (control_in),
        .last_input_in(last_input_in),
        .line_out     (line_out),
        .line_mask    (line_mask),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .in_ready     (in_ready),
        .done_out     (done_out),
        .update_count (update_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] upd(input logic [31:0] d);
        return {d ^ WK, d};
    endfunction

    function automatic logic [511:0] mk_line(input int n, input logic [31:0] d [8]);
        logic [511:0] l = '0;
        for (int j = 0; j < n; j++) l[j*64 +: 64] = upd(d[j]);
        return l;
    endfunction

    function automatic logic [7:0] mk_mask(input int n);
        logic [7:0] m = '0;
        for (int j = 0; j < n; j++) m[j] = 1'b1;
        return m;
    endfunction

    task automatic exp_list(input int n, input logic [31:0] d [8]);
        exp_t e;
        e.line = mk_line(n, d);
        e.mask = mk_mask(n);
        sb.push_back(e);
    endtask

    task automatic exp_seq(input int n, input logic [31:0] base);
        logic [31:0] d [8];
        for (int j = 0; j < 8; j++) d[j] = base + 32'(j);
        exp_list(n, d);
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e,
                         input logic [1:0] ctrl = 2'h2, input logic last = 1'b0);
        upd_in[0 +: 64]   = upd(a);
        upd_in[64 +: 64]  = upd(b);
        upd_in[128 +: 64] = upd(c);
        upd_in[192 +: 64] = upd(e);
        upd_valid     = v;
        control_in    = ctrl;
        last_input_in = last;
        @(posedge clk);
        #1;
        upd_valid     = '0;
        last_input_in = 1'b0;
        control_in    = 2'h2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every transfer pops one expected line
    always @(negedge clk) begin
        if (rst && done_out) done_cnt++;
        if (rst && line_valid && line_ready) begin
            exp_t e;
            prev_pop = last_pop;
            last_pop = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line actual_mask=%0h required=none", line_mask);
            end else begin
                e = sb.pop_front();
                chk("line_data", line_out, e.line);
                chk("line_mask", 512'(line_mask), 512'(e.mask));
            end
        end
    end

    initial begin
        logic [31:0]  d8 [8];
        logic [511:0] l0;
        int           d0;

        rst = 1'b1;
        upd_in = '0;
        upd_valid = '0;
        control_in = 2'h2;
        last_input_in = 1'b0;
        line_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_line_valid", 512'(line_valid), 512'(0));
        chk("rst_line_out", line_out, '0);
        chk("rst_line_mask", 512'(line_mask), 512'(0));
        chk("rst_done", 512'(done_out), 512'(0));
        chk("rst_count", 512'(update_count), 512'(0));
        chk("rst_overflow", 512'(overflow), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        rst = 1'b1;
        idle(1);

        // Single-lane fill
        exp_seq(8, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("single_not_early", 512'(line_valid), 512'(0));
            drive(4'b0001, 32'(i), 0, 0, 0);
        end
        chk("single_valid_next", 512'(line_valid), 512'(1));
        chk("single_count", 512'(update_count), 512'(8));
        idle(3);

        // Mixed compaction, then flush of the one leftover
        d8 = '{32'd1, 32'd3, 32'd10, 32'd11, 32'd12, 32'd13, 32'd20, 32'd21};
        exp_list(8, d8);
        d8 = '{32'd22, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_list(1, d8);
        drive(4'b1010, 0, 1, 0, 3);
        drive(4'b1111, 10, 11, 12, 13);
        drive(4'b0111, 20, 21, 22, 0);
        chk("mixed_count", 512'(update_count), 512'(17));
        d0 = done_cnt;
        drive(4'b0000, 0, 0, 0, 0, 2'h2, 1'b1);
        idle(8);
        chk("mixed_done", 512'(done_cnt), 512'(d0 + 1));

        // Flush partial line
        exp_seq(3, 30);
        drive(4'b0111, 30, 31, 32, 0);
        d0 = done_cnt;
        drive(4'b0000, 0, 0, 0, 0, 2'h2, 1'b1);
        idle(1);
        chk("partial_done_not_early", 512'(done_cnt), 512'(d0));
        idle(6);
        chk("partial_done_once", 512'(done_cnt), 512'(d0 + 1));

        // Flush coinciding with a full line
        exp_seq(8, 40);
        exp_seq(2, 48);
        drive(4'b1111, 40, 41, 42, 43);
        drive(4'b0011, 44, 45, 0, 0);
        d0 = done_cnt;
        drive(4'b1111, 46, 47, 48, 49, 2'h2, 1'b1);
        idle(8);
        chk("coinc_done_once", 512'(done_cnt), 512'(d0 + 1));
        chk("coinc_back_to_back", 512'(last_pop - prev_pop), 512'(1));

        // Clear mid-accumulation; empty flush yields no line
        drive(4'b0011, 50, 51, 0, 0);
        drive(4'b1111, 60, 61, 62, 63, 2'h1, 1'b0);
        chk("clear_count", 512'(update_count), 512'(0));
        d0 = done_cnt;
        drive(4'b0000, 0, 0, 0, 0, 2'h2, 1'b1);
        idle(6);
        chk("clear_flush_done", 512'(done_cnt), 512'(d0 + 1));
        chk("clear_count_held", 512'(update_count), 512'(0));

        // Backpressure and overflow
        line_ready = 1'b0;
        for (int j = 0; j < 8; j++) d8[j] = 32'd100 + 32'(j);
        l0 = mk_line(8, d8);
        for (int i = 0; i < 4; i++) exp_seq(8, 32'(100 + 8 * i));
        for (int i = 0; i < 10; i++) begin
            drive(4'b1111, 32'(100 + 4 * i), 32'(101 + 4 * i), 32'(102 + 4 * i), 32'(103 + 4 * i));
            if (i >= 1) begin
                chk("bp_valid", 512'(line_valid), 512'(1));
                chk("bp_stable", line_out, l0);
            end
            if (i == 3) chk("bp_in_ready_2q", 512'(in_ready), 512'(1));
            if (i == 5) chk("bp_in_ready_3q", 512'(in_ready), 512'(0));
            if (i == 7) chk("bp_no_ovf_yet", 512'(overflow), 512'(0));
        end
        chk("bp_overflow", 512'(overflow), 512'(1));
        chk("bp_count", 512'(update_count), 512'(40));
        line_ready = 1'b1;
        idle(8);
        chk("bp_drained", 512'(sb.size()), 512'(0));
        drive(4'b0000, 0, 0, 0, 0, 2'h1, 1'b0);
        chk("bp_ovf_cleared", 512'(overflow), 512'(0));

        // Async reset while a line is presented
        line_ready = 1'b0;
        drive(4'b1111, 200, 201, 202, 203);
        drive(4'b1111, 204, 205, 206, 207);
        drive(4'b0001, 208, 0, 0, 0);
        chk("pre_rst_valid", 512'(line_valid), 512'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 512'(line_valid), 512'(0));
        chk("async_line", line_out, '0);
        chk("async_mask", 512'(line_mask), 512'(0));
        chk("async_count", 512'(update_count), 512'(0));
        chk("async_in_ready", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        line_ready = 1'b1;
        d0 = done_cnt;
        drive(4'b0000, 0, 0, 0, 0, 2'h2, 1'b1);
        idle(6);
        chk("post_rst_done", 512'(done_cnt), 512'(d0 + 1));
        chk("final_sb_empty", 512'(sb.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
